// File: rtl/alu32_sched.sv
// alu32_sched: round-robin scheduler sharing one external combinational ALU
// between two requesters.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   req_valid[1:0]        per-requester request valid
//   req_op0/1, req_a0/1,
//   req_b0/1              per-requester opcode and operands
//   req_ready[1:0]        per-requester accept strobe (combinational)
//   alu_op, alu_a, alu_b  registered operands driven to the ALU
//   alu_result, alu_zero,
//   alu_carry, alu_ovf    ALU result and flags
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                requester index of the response
//   rsp_result, rsp_zero,
//   rsp_carry, rsp_ovf    captured result and flags
//   busy                  high whenever the scheduler is not idle
module alu32_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       req_valid,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic [1:0]       w_grant;
  logic             w_gnt_idx;
  logic             r_last_grant;
  logic             r_tag;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic             r_rsp_ovf;

  // Round-robin arbitration: on contention favour the requester not granted last.
  always_comb begin
    w_grant = 2'b00;
    unique case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_gnt_idx = w_grant[1];

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and accept strobe.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready   = w_grant;
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch on grant; response capture at the end of ISSUE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_last_grant <= 1'b1;
      r_tag        <= 1'b0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt_idx;
        r_tag        <= w_gnt_idx;
        r_alu_op     <= w_gnt_idx ? req_op1 : req_op0;
        r_alu_a      <= w_gnt_idx ? req_a1  : req_a0;
        r_alu_b      <= w_gnt_idx ? req_b1  : req_b0;
      end
      if (r_state == S_ISSUE) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= r_tag;
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_carry  <= alu_carry;
        r_rsp_ovf    <= alu_ovf;
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_ovf    = r_rsp_ovf;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu32_sched.sv
// tb_alu32_sched: self-checking bench for alu32_sched with a combinational
// ALU stub, hand-computed vectors, directed corner sequences and a
// transaction-level reference model for random traffic.
module tb_alu32_sched;

  logic        clk;
  logic        n_rst;
  logic [1:0]  req_valid;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_ready;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_carry, alu_ovf;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_carry, rsp_ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
  } alu_res_t;

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          z;
    bit          c;
    bit          v;
  } vec_t;

  // Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass a.
  function automatic alu_res_t alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_res_t   x;
    logic [32:0] s;
    x = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        x.r = s[31:0]; x.c = s[32];
        x.v = (a[31] == b[31]) && (x.r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        x.r = s[31:0]; x.c = s[32];
        x.v = (a[31] != b[31]) && (x.r[31] != a[31]);
      end
      3'd2:    x.r = a & b;
      3'd3:    x.r = a | b;
      3'd4:    x.r = a ^ b;
      default: x.r = a;
    endcase
    x.z = (x.r == 32'd0);
    return x;
  endfunction

  alu32_sched #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  // Combinational ALU stub.
  always_comb begin
    alu_res_t w;
    w          = alu_f(alu_op, alu_a, alu_b);
    alu_result = w.r;
    alu_zero   = w.z;
    alu_carry  = w.c;
    alu_ovf    = w.v;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: one transaction in flight, aged in cycles since accept.
  bit          m_inflight;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  alu_res_t    m_rsp;

  function automatic logic [1:0] arb(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_age = 0; m_last = 1;
  endtask

  // Drive one cycle of inputs at the falling edge, check against the model, advance the model.
  task automatic step(input logic [1:0] v, input logic rdy,
                      input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1);
    logic [1:0] er;
    @(negedge clk);
    req_valid = v; rsp_ready = rdy;
    req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1;
    #1;
    er = m_inflight ? 2'b00 : arb(v, m_last);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_inflight && (m_age >= 2)));
    if (m_inflight) begin
      chk("alu_op", 32'(alu_op), 32'(m_op));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (m_age >= 2) begin
        chk("rsp_result", rsp_result, m_rsp.r);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_rsp.z));
        chk("rsp_carry", 32'(rsp_carry), 32'(m_rsp.c));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_rsp.v));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end
    if (m_inflight) begin
      if (m_age >= 2 && rdy) m_inflight = 0;
      else m_age++;
    end else if (er != 2'b00) begin
      m_inflight = 1; m_age = 1;
      m_id = er[1]; m_last = er[1];
      m_op = er[1] ? o1 : o0;
      m_a  = er[1] ? a1 : a0;
      m_b  = er[1] ? b1 : b0;
      m_rsp = alu_f(m_op, m_a, m_b);
    end
  endtask

  task automatic idle_step(input logic [1:0] v, input logic rdy);
    step(v, rdy, 3'($urandom_range(0, 7)), $urandom, $urandom,
                 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[8];

  initial begin
    bit first_exp;
    int ng;
    logic [1:0] v;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 3'd0, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd1, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 3'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0,         1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 3'd0, 32'h1,         32'h1,         32'h2,         1'b0, 1'b0, 1'b0};

    n_rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    req_op0 = '0; req_a0 = '0; req_b0 = '0; req_op1 = '0; req_a1 = '0; req_b1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'({rsp_id, rsp_zero, rsp_carry, rsp_ovf}), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_ab", alu_a | alu_b, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    n_rst = 1'b1;

    // Hand-computed vectors; operands scrambled right after accept.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i].id ? 2'b10 : 2'b01;
      step(v, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].a, vecs[i].b);
      chk("vec_accept", 32'(req_ready), 32'(v));
      step(2'b00, 1'b1, 3'($urandom_range(0, 7)), 32'hFFFF_FFFF, $urandom,
                        3'($urandom_range(0, 7)), 32'hFFFF_FFFF, $urandom);
      idle_step(2'b00, 1'b1);
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("vec_result", rsp_result, vecs[i].r);
      chk("vec_flags", 32'({rsp_zero, rsp_carry, rsp_ovf}), 32'({vecs[i].z, vecs[i].c, vecs[i].v}));
      chk("vec_id", 32'(rsp_id), 32'(vecs[i].id));
      idle_step(2'b00, 1'b1);
      chk("vec_idle", 32'(busy), 32'd0);
    end

    // Contention: both valid for four back-to-back ops.
    first_exp = !m_last;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      idle_step(2'b11, 1'b1);
      if (req_ready != 2'b00) begin
        chk("cont_grant", 32'(req_ready[1]), 32'(first_exp ^ ng[0]));
        chk("cont_spacing", 32'(c), 32'(ng * 3));
        ng++;
      end
    end
    chk("cont_count", 32'(ng), 32'd4);
    idle_step(2'b00, 1'b1);

    // Backpressure: rsp_ready low for five cycles after rsp_valid rises.
    step(2'b01, 1'b1, 3'd0, 32'd100, 32'd23, 3'd0, 32'd0, 32'd0);
    idle_step(2'b11, 1'b0);
    ra = 0;
    for (int c = 0; c < 5; c++) begin
      idle_step(2'b11, 1'b0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_result", rsp_result, 32'd123);
    end
    idle_step(2'b00, 1'b1);
    idle_step(2'b00, 1'b1);
    chk("bp_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a response.
    step(2'b10, 1'b0, 3'd0, 32'd0, 32'd0, 3'd0, 32'd5, 32'd7);
    idle_step(2'b00, 1'b0);
    idle_step(2'b00, 1'b0);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    model_reset();
    @(negedge clk);
    #1 n_rst = 1'b1;
    idle_step(2'b11, 1'b1);
    chk("rst_first_grant", 32'(req_ready), 32'd1);
    idle_step(2'b00, 1'b1);
    idle_step(2'b00, 1'b1);
    idle_step(2'b00, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      ra = rnd_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd_operand();
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), ra, rb,
           3'($urandom_range(0, 7)), rnd_operand(), rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu32_sched.md
# alu32_sched

Round-robin scheduler that shares one combinational 32-bit ALU datapath (adder/logic unit plus tree-structured zero detector) between two requesters. Each request is accepted with a valid/ready handshake, its operands are registered, the ALU is driven for one cycle, and the result and flags are returned on a single response channel with backpressure and a requester tag. The block sits between the requesting units and the ALU; the ALU itself stays purely combinational.

## Interface
Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_op0, req_op1  in  OPW  opcode from requester 0 / 1.
- req_a0, req_b0, req_a1, req_b1  in  WIDTH  operands from requester 0 / 1.
- req_ready  out  2  per-requester accept strobe (combinational).
- alu_op  out  OPW  opcode to ALU (registered).
- alu_a, alu_b  out  WIDTH  operands to ALU (registered).
- alu_result  in  WIDTH  ALU result.
- alu_zero, alu_carry, alu_ovf  in  1  ALU flags.
- rsp_valid  out  1  response valid (registered).
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of the response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero, rsp_carry, rsp_ovf  out  1  captured flags.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if no req_valid bit set, stay. Otherwise grant one requester, assert its req_ready bit, latch its op/a/b into alu_op/alu_a/alu_b and the index into a tag register, then go to ISSUE.
- Arbitration: last_grant register, reset value 1. One requester valid → grant it. Both valid → grant !last_grant. On every grant last_grant ← granted index.
- req_ready[i] = (state == IDLE) && grant[i]; at most one bit high; never high outside IDLE.
- ISSUE: ALU sees registered operands for the full cycle; at the closing edge capture alu_result, alu_zero, alu_carry, alu_ovf into rsp_* regs, rsp_id ← tag, rsp_valid ← 1, go to RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid ← 0, go to IDLE. No new request is accepted in RESP.
- alu_op/alu_a/alu_b change only on an IDLE grant; they hold otherwise.
- Requester must hold op/a/b stable only in the accept cycle; later changes have no effect on an in-flight op.
- Requester deasserting req_valid before a grant is legal; nothing is latched.
- busy = (state != IDLE).

## Timing
- Reset (n_rst low, any time, asynchronous): state IDLE, last_grant 1, rsp_valid 0, rsp_id 0, rsp_result 0, all rsp flags 0, alu_op/alu_a/alu_b 0, busy 0. An in-flight operation is dropped with no response.
- Latency: accept in cycle N (req_ready high), ISSUE in N+1, rsp_valid high from N+2.
- With rsp_ready held high: response lasts exactly one cycle (N+2), IDLE in N+3, next accept no earlier than N+3. Peak throughput one op per 3 cycles.
- Backpressure: each cycle rsp_ready stays low extends RESP by one cycle; rsp_* unchanged meanwhile.
- rsp_zero equals alu_zero sampled in ISSUE. The scheduler never recomputes it.

## Test plan
- Reset: drive n_rst low mid-RESP with rsp_valid=1 → rsp_valid, rsp_result, busy drop to 0 immediately. The first grant after release goes to requester 0 when both are valid.
- Single request: req_valid=01, op=ADD, a=5, b=7 → req_ready=01 in cycle N. rsp_valid in N+2 with rsp_result=12, rsp_zero=0, rsp_id=0.
- Zero flag: requester 1, SUB, a=b=0x1234_5678 → rsp_result=0, rsp_zero=1, rsp_id=1.
- Contention: req_valid=11 held for 4 ops with rsp_ready=1 → grants alternate 0,1,0,1. Accepts occur every 3 cycles.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises → rsp_* stable, req_ready=00 throughout. Release → IDLE the next cycle.
- Operand isolation: change req_a0 to 0xFFFF_FFFF in the cycle after accept of a=1, b=1, ADD → rsp_result=2.
